// File: rtl/roi_scan_ctrl.sv
// roi_scan_ctrl: overlapped scan sequencer for the minitest serial harness.
// Each transaction shifts a vector in on scan_di while the previous response shifts out on scan_do, then strobes.
module roi_scan_ctrl #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIN_N-1:0]  vec_in,
  output logic              busy,
  output logic              done,
  output logic [DOUT_N-1:0] vec_out,
  output logic              resp_valid,
  output logic              scan_di,
  output logic              scan_stb,
  input  logic              scan_do
);
  localparam int N     = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] RX_LEN = CNT_W'(DOUT_N);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STROBE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [N-1:0]      r_tx;
  logic [DOUT_N-1:0] r_rx;
  logic              r_strobed;
  logic [N-1:0]      w_tx_load;
  logic              w_accept;
  logic              w_shift_last;
  logic              w_strobe_end;

  // Zero-extending into the top bits yields the leading padding when DIN_N < N.
  always_comb begin
    w_tx_load              = '0;
    w_tx_load[DIN_N-1:0]   = vec_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_shift_last = 1'b0;
    w_strobe_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_K) begin
          w_shift_last = 1'b1;
          w_state_nxt  = S_STROBE;
        end
      end
      S_STROBE: begin
        w_strobe_end = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // scan_di is registered, so the first bit is launched on the accepting edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_strobed  <= 1'b0;
      scan_di    <= 1'b0;
      scan_stb   <= 1'b0;
      done       <= 1'b0;
      vec_out    <= '0;
      resp_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      scan_stb <= 1'b0;
      scan_di  <= 1'b0;
      if (w_accept) begin
        r_cnt   <= '0;
        scan_di <= w_tx_load[N-1];
        r_tx    <= w_tx_load << 1;
      end
      if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt < RX_LEN) r_rx <= {r_rx[DOUT_N-2:0], scan_do};
        if (w_shift_last) begin
          scan_stb <= 1'b1;
        end else begin
          scan_di <= r_tx[N-1];
          r_tx    <= r_tx << 1;
        end
      end
      if (w_strobe_end) begin
        done      <= 1'b1;
        vec_out   <= r_rx;
        r_strobed <= 1'b1;
        if (r_strobed) resp_valid <= 1'b1;
      end
    end
  end

endmodule
